// File: rtl/vram_pkg.sv
// -----------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the video RAM arbiter: default RAM geometry, the
// access sequencer state encoding and the requester (owner) encoding.
// -----------------------------------------------------------------------------
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 13;   // 8192 bytes
    localparam int unsigned VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

endpackage

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port BSRAM (1-cycle read latency, bypass mode) between the
// Z80 CPU bus (read/write) and the video scan-out fetcher (read-only).
// Every access runs IDLE -> ACCESS -> CAPTURE -> DONE, so a request seen in
// IDLE at cycle T is acknowledged in cycle T+3 and a new grant is possible
// every 4 cycles. When both requesters wait, ownership alternates.
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   cpu_req/we/addr/din   : CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_dout     : one-cycle completion pulse, read data
//   vid_req/addr          : video fetch request (level, held until vid_ack)
//   vid_ack, vid_data     : one-cycle completion pulse, fetched byte
//   ram_ce/oce/wre/ad/din : RAM control, address and write data
//   ram_dout              : RAM read data
//   ram_reset             : RAM reset, follows reset
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W,
    parameter int unsigned DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_dout,

    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_data,

    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              ram_reset
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_owner_q, last_owner_d;
    logic                is_write_q, is_write_d;
    logic                grant_cpu_s;

    logic                ram_ce_q, ram_ce_d;
    logic                ram_wre_q, ram_wre_d;
    logic [ADDR_W-1:0]   ram_ad_q, ram_ad_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0]   cpu_dout_q, cpu_dout_d;
    logic                vid_ack_q, vid_ack_d;
    logic [DATA_W-1:0]   vid_data_q, vid_data_d;

    // Grant selection: a lone requester wins; on contention the side that did
    // not own the previous access wins, so the CPU waits for at most one fetch.
    always_comb begin
        grant_cpu_s = 1'b0;
        if (cpu_req && vid_req) begin
            grant_cpu_s = (last_owner_q == OWN_VID);
        end else begin
            grant_cpu_s = cpu_req;
        end
    end

    // Access sequencer: next state and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        is_write_d   = is_write_q;
        ram_ce_d     = 1'b0;
        ram_wre_d    = 1'b0;
        ram_ad_d     = ram_ad_q;
        ram_din_d    = ram_din_q;
        cpu_ack_d    = 1'b0;
        cpu_dout_d   = cpu_dout_q;
        vid_ack_d    = 1'b0;
        vid_data_d   = vid_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || vid_req) begin
                    // Request fields are captured here and never looked at again.
                    state_d  = ST_ACCESS;
                    ram_ce_d = 1'b1;
                    if (grant_cpu_s) begin
                        owner_d    = OWN_CPU;
                        is_write_d = cpu_we;
                        ram_wre_d  = cpu_we;
                        ram_ad_d   = cpu_addr;
                        ram_din_d  = cpu_din;
                    end else begin
                        owner_d    = OWN_VID;
                        is_write_d = 1'b0;
                        ram_wre_d  = 1'b0;
                        ram_ad_d   = vid_addr;
                        ram_din_d  = {DATA_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                // The RAM performs the access at the edge closing this cycle.
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                // ram_dout now holds the addressed byte; writes keep old data.
                state_d = ST_DONE;
                if (owner_q == OWN_CPU) begin
                    cpu_ack_d = 1'b1;
                    if (!is_write_q) begin
                        cpu_dout_d = ram_dout;
                    end else begin
                        cpu_dout_d = cpu_dout_q;
                    end
                end else begin
                    vid_ack_d = 1'b1;
                    if (!is_write_q) begin
                        vid_data_d = ram_dout;
                    end else begin
                        vid_data_d = vid_data_q;
                    end
                end
            end

            ST_DONE: begin
                // Ack is visible this cycle; the requester drops req at its end,
                // and the following IDLE cycle prevents a second service.
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_VID;
            last_owner_q <= OWN_VID;
            is_write_q   <= 1'b0;
            ram_ce_q     <= 1'b0;
            ram_wre_q    <= 1'b0;
            ram_ad_q     <= {ADDR_W{1'b0}};
            ram_din_q    <= {DATA_W{1'b0}};
            cpu_ack_q    <= 1'b0;
            cpu_dout_q   <= {DATA_W{1'b0}};
            vid_ack_q    <= 1'b0;
            vid_data_q   <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            is_write_q   <= is_write_d;
            ram_ce_q     <= ram_ce_d;
            ram_wre_q    <= ram_wre_d;
            ram_ad_q     <= ram_ad_d;
            ram_din_q    <= ram_din_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_dout_q   <= cpu_dout_d;
            vid_ack_q    <= vid_ack_d;
            vid_data_q   <= vid_data_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_dout  = cpu_dout_q;
    assign vid_ack   = vid_ack_q;
    assign vid_data  = vid_data_q;
    assign ram_ce    = ram_ce_q;
    assign ram_wre   = ram_wre_q;
    assign ram_ad    = ram_ad_q;
    assign ram_din   = ram_din_q;
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Randomized bench for vram_arbiter with a behavioural RAM and a
// transaction-level reference model: a grant is taken whenever the arbiter is
// free and a request is present, its ack falls 3 cycles later, and a shadow
// memory array supplies the expected read data.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int AW = 13;
    localparam int DW = 8;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } req_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din, cpu_dout;
    logic          vid_req, vid_ack;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          ram_ce, ram_oce, ram_wre, ram_reset;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_reset(ram_reset)
    );

    // Behavioural single-port RAM with registered (1-cycle) read data.
    logic [DW-1:0] mem [0:8191];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            else         ram_dout    <= mem[ram_ad];
        end
    end

    // ---------------- reference model and requester state ----------------
    logic [DW-1:0] shadow [0:8191];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc;
    bit            acc_live, acc_cpu, acc_we, last_cpu;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_din, acc_data;
    int            acc_grant;
    logic [DW-1:0] hold_cpu, hold_vid;
    bit            cpu_pend, vid_pend, cpu_granted, vid_granted;
    int            cpu_start, vid_start;
    int            cpu_rate, vid_rate;
    bit            strict, watch_first, inject_rst, force_rst;
    req_t          cpu_q[$];
    req_t          vid_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] preload(input int i);
        return 8'((i * 7 + 60) & 255);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = 13'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a | 13'h1FF0;
        return a;
    endfunction

    // Drive the inputs for the cycle that has just begun (called #1 after posedge).
    task automatic drive_inputs();
        req_t r;
        bit   start;
        reset = 1'b0;
        if (inject_rst && acc_live && acc_cpu && acc_we && acc_addr == 13'h0100 &&
            cyc == acc_grant + 1) begin
            reset      = 1'b1;
            inject_rst = 1'b0;
        end else if (force_rst) begin
            reset     = 1'b1;
            force_rst = 1'b0;
        end
        if (reset) begin
            cpu_req = 1'b0;
            vid_req = 1'b0;
            return;
        end
        // CPU requester
        if (!cpu_pend) begin
            start = 1'b0;
            if (cpu_q.size() > 0) begin
                r = cpu_q.pop_front(); start = 1'b1;
            end else if ($urandom_range(0, 99) < cpu_rate) begin
                r.we = 1'($urandom_range(0, 1)); r.addr = rand_addr(); r.din = 8'($urandom);
                start = 1'b1;
            end
            if (start) begin
                cpu_pend = 1'b1; cpu_start = cyc;
                cpu_we = r.we; cpu_addr = r.addr; cpu_din = r.din;
            end
        end else if (cpu_granted) begin
            // After grant the fields are free to change.
            cpu_we = 1'($urandom_range(0, 1)); cpu_addr = rand_addr(); cpu_din = 8'($urandom);
        end
        cpu_req = cpu_pend;
        // Video requester
        if (!vid_pend) begin
            start = 1'b0;
            if (vid_q.size() > 0) begin
                r = vid_q.pop_front(); start = 1'b1;
            end else if ($urandom_range(0, 99) < vid_rate) begin
                r.addr = rand_addr(); start = 1'b1;
            end
            if (start) begin
                vid_pend = 1'b1; vid_start = cyc; vid_addr = r.addr;
            end
        end else if (vid_granted) begin
            vid_addr = rand_addr();
        end
        vid_req = vid_pend;
    endtask

    // One clock cycle: model the grant, check outputs mid-cycle, advance.
    task automatic tick();
        bit exp_ce, exp_wre, done, exp_cack, exp_vack, win;
        if (!reset && !acc_live && (cpu_req || vid_req)) begin
            win       = cpu_req && (!vid_req || !last_cpu);
            acc_live  = 1'b1;
            acc_cpu   = win;
            acc_grant = cyc;
            last_cpu  = win;
            if (win) begin
                acc_we = cpu_we; acc_addr = cpu_addr; acc_din = cpu_din; cpu_granted = 1'b1;
            end else begin
                acc_we = 1'b0; acc_addr = vid_addr; acc_din = 8'h00; vid_granted = 1'b1;
            end
            if (acc_we) shadow[acc_addr] = acc_din;
            else        acc_data = shadow[acc_addr];
        end

        @(negedge clk);
        exp_ce   = acc_live && (cyc == acc_grant + 1);
        exp_wre  = exp_ce && acc_we;
        done     = acc_live && (cyc == acc_grant + 3);
        exp_cack = done && acc_cpu;
        exp_vack = done && !acc_cpu;
        if (exp_cack && !acc_we) hold_cpu = acc_data;
        if (exp_vack)            hold_vid = acc_data;

        chk("cpu_ack",   cpu_ack,   exp_cack);
        chk("vid_ack",   vid_ack,   exp_vack);
        chk("ram_ce",    ram_ce,    exp_ce);
        chk("ram_wre",   ram_wre,   exp_wre);
        chk("cpu_dout",  cpu_dout,  hold_cpu);
        chk("vid_data",  vid_data,  hold_vid);
        chk("ram_oce",   ram_oce,   1'b1);
        chk("ram_reset", ram_reset, reset);
        if (exp_ce) begin
            chk("ram_ad", ram_ad, acc_addr);
            if (acc_we) chk("ram_din", ram_din, acc_din);
        end
        if (strict && cpu_ack && cpu_pend) chk("cpu_wait_le7", (cyc - cpu_start) <= 7, 1'b1);
        if (strict && vid_ack && vid_pend) chk("vid_wait_le7", (cyc - vid_start) <= 7, 1'b1);
        if (watch_first && (cpu_ack || vid_ack)) begin
            chk("first_grant_cpu", cpu_ack, 1'b1);
            watch_first = 1'b0;
        end

        if (done) begin
            acc_live = 1'b0;
            if (acc_cpu) begin cpu_pend = 1'b0; cpu_granted = 1'b0; end
            else         begin vid_pend = 1'b0; vid_granted = 1'b0; end
        end
        if (reset) begin
            acc_live = 1'b0; last_cpu = 1'b0; hold_cpu = 8'h00; hold_vid = 8'h00;
            cpu_pend = 1'b0; vid_pend = 1'b0; cpu_granted = 1'b0; vid_granted = 1'b0;
        end

        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]    = preload(i);
            shadow[i] = preload(i);
        end
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0000; cpu_din = 8'h00;
        vid_req = 1'b0; vid_addr = 13'h0000;
        acc_live = 1'b0; last_cpu = 1'b0; hold_cpu = 8'h00; hold_vid = 8'h00;
        cpu_pend = 1'b0; vid_pend = 1'b0; cpu_granted = 1'b0; vid_granted = 1'b0;
        cpu_rate = 0; vid_rate = 0; strict = 1'b0; watch_first = 1'b0;
        inject_rst = 1'b0; force_rst = 1'b0; cyc = 0; acc_grant = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ack",   cpu_ack,   1'b0);
        chk("rst_vid_ack",   vid_ack,   1'b0);
        chk("rst_cpu_dout",  cpu_dout,  8'h00);
        chk("rst_vid_data",  vid_data,  8'h00);
        chk("rst_ram_ce",    ram_ce,    1'b0);
        chk("rst_ram_wre",   ram_wre,   1'b0);
        chk("rst_ram_ad",    ram_ad,    13'h0000);
        chk("rst_ram_din",   ram_din,   8'h00);
        chk("rst_ram_oce",   ram_oce,   1'b1);
        chk("rst_ram_reset", ram_reset, 1'b1);
        @(posedge clk);
        #1;
        drive_inputs();

        // CPU write then read-back of 0x1800
        cpu_q.push_back('{1'b1, 13'h1800, 8'hA5});
        cpu_q.push_back('{1'b0, 13'h1800, 8'h00});
        run(16);
        chk("cpu_readback_1800", cpu_dout, 8'hA5);

        // Video-only fetch of preloaded address 0, then a burst of fetches
        vid_q.push_back('{1'b0, 13'h0000, 8'h00});
        run(8);
        chk("vid_fetch_0000", vid_data, 8'h3C);
        vid_rate = 100;
        run(40);
        vid_rate = 0;
        run(10);

        // Both held continuously straight after reset: CPU first, then alternate
        force_rst = 1'b1; watch_first = 1'b1; strict = 1'b1;
        cpu_rate = 100; vid_rate = 100;
        run(60);
        cpu_rate = 0; vid_rate = 0;
        run(12);
        strict = 1'b0;

        // Fields scrambled after grant must not affect the write
        cpu_q.push_back('{1'b1, 13'h0777, 8'hC3});
        cpu_q.push_back('{1'b0, 13'h0777, 8'h00});
        run(16);
        chk("scramble_readback", cpu_dout, 8'hC3);

        // Reset during ACCESS of a CPU write: no ack, but the write sticks
        inject_rst = 1'b1;
        cpu_q.push_back('{1'b1, 13'h0100, 8'h5A});
        cpu_q.push_back('{1'b0, 13'h0100, 8'h00});
        run(20);
        chk("rst_write_kept", cpu_dout, 8'h5A);

        // Mixed random traffic
        cpu_rate = 40; vid_rate = 40;
        run(1500);
        cpu_rate = 0; vid_rate = 0;
        run(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
